// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory req/ack bus between fetch_stage and imem
interface fetch_stage_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;

    // fetch_stage drives the request, memory answers with ack/rdata
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, skid buffer and redirects (optional FETCH_PERF_EN counters)
module fetch_stage #(
    parameter int                 PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [25:0]         jump_index,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc4,
    output logic [5:0]          opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                req_q;
    logic [PC_WIDTH-1:0] req_addr_q;
    logic                if_valid_q;
    logic [31:0]         if_instr_q;
    logic [PC_WIDTH-1:0] if_pc4_q;
    logic                skid_valid_q;
    logic [31:0]         skid_instr_q;
    logic [PC_WIDTH-1:0] skid_pc4_q;

    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                ack_v;
    logic [PC_WIDTH-1:0] req_pc4;

    // Branch from EX is older than a jump in ID, so it wins the target select.
    // An ack only counts while our own request is up; stale acks after reset are dropped.
    always_comb begin
        redirect    = branch_taken | jump;
        redirect_pc = branch_taken ? branch_target
                                   : {if_pc4_q[PC_WIDTH-1:28], jump_index, 2'b00};
        ack_v       = imem.imem_ack & req_q;
        req_pc4     = req_addr_q + PC_WIDTH'(4);
    end

    // Fetch FSM: owns the PC, the outstanding request, the skid buffer and IF/ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            req_addr_q   <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0;
            if_pc4_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        // First cycle out of reset: open the request at the current pc,
                        // or straight at the redirect target if one is already pending.
                        req_q      <= 1'b1;
                        req_addr_q <= redirect ? redirect_pc : pc_q;
                        pc_q       <= redirect ? redirect_pc : pc_q;
                        if (redirect) begin
                            if_valid_q   <= 1'b0;
                            if_instr_q   <= 32'h0;
                            skid_valid_q <= 1'b0;
                        end
                    end else if (redirect) begin
                        if_valid_q   <= 1'b0;
                        if_instr_q   <= 32'h0;
                        skid_valid_q <= 1'b0;
                        pc_q         <= redirect_pc;
                        if (ack_v) begin
                            // Wrong-path word arrived this cycle: drop it, restart at target.
                            req_addr_q <= redirect_pc;
                        end else begin
                            // Memory still owes us the old word; wait it out at the old address.
                            state_q <= ST_DRAIN;
                        end
                    end else if (ack_v) begin
                        pc_q <= req_pc4;
                        if (stall) begin
                            skid_valid_q <= 1'b1;
                            skid_instr_q <= imem.imem_rdata;
                            skid_pc4_q   <= req_pc4;
                            req_q        <= 1'b0;
                            state_q      <= ST_HOLD;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_instr_q <= imem.imem_rdata;
                            if_pc4_q   <= req_pc4;
                            req_addr_q <= req_pc4;
                        end
                    end
                end

                ST_HOLD: begin
                    if (redirect) begin
                        if_valid_q   <= 1'b0;
                        if_instr_q   <= 32'h0;
                        skid_valid_q <= 1'b0;
                        pc_q         <= redirect_pc;
                        req_q        <= 1'b1;
                        req_addr_q   <= redirect_pc;
                        state_q      <= ST_FETCH;
                    end else if (!stall) begin
                        if_valid_q   <= skid_valid_q;
                        if_instr_q   <= skid_instr_q;
                        if_pc4_q     <= skid_pc4_q;
                        skid_valid_q <= 1'b0;
                        req_q        <= 1'b1;
                        req_addr_q   <= pc_q;
                        state_q      <= ST_FETCH;
                    end
                end

                ST_DRAIN: begin
                    // IF/ID is already flushed; later redirects only move the pc.
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end
                    if (ack_v) begin
                        req_addr_q <= redirect ? redirect_pc : pc_q;
                        state_q    <= ST_FETCH;
                    end
                end

                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = req_addr_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc4         = if_pc4_q;
    assign opcode         = if_instr_q[31:26];

`ifdef FETCH_PERF_EN
    logic fetch_accept;

    // Only acks that actually land in IF/ID or the skid buffer are counted.
    always_comb begin
        fetch_accept = (state_q == ST_FETCH) & ack_v & ~redirect;
    end

    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            if (fetch_accept && fetch_count_q != 32'hFFFF_FFFF) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (stall && if_valid_q && stall_count_q != 32'hFFFF_FFFF) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic [5:0]  opcode;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int compares = 0;
    int fails    = 0;

    fetch_stage_if #(.PC_WIDTH(32)) imem_bus ();

    fetch_stage #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem_bus),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc4        (if_pc4),
        .opcode        (opcode)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] w(input logic [31:0] a);
        return {a[7:2] ^ 6'h2A, a[25:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic zw(input logic [31:0] a);
        chk("zw_req", 32'(imem_bus.imem_req), 32'h1);
        chk("zw_addr", imem_bus.imem_addr, a);
        tick();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(a);
        tick();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
        chk({tag, "_valid"}, 32'(if_valid), 32'(v));
        chk({tag, "_instr"}, if_instr, ins);
        chk({tag, "_pc4"}, if_pc4, p4);
        chk({tag, "_opcode"}, 32'(opcode), 32'(ins[31:26]));
    endtask

    initial begin
        rst                 = 1'b1;
        stall               = 1'b0;
        branch_taken        = 1'b0;
        branch_target       = 32'h0;
        jump                = 1'b0;
        jump_index          = 26'h0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
        chk_ifid("rst", 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
        chk("first_req", 32'(imem_bus.imem_req), 32'h1);

        // Zero-wait sequential fetch
        zw(32'h0);
        chk_ifid("seq0", 1'b1, w(32'h0), 32'h4);
        zw(32'h4);
        chk_ifid("seq4", 1'b1, w(32'h4), 32'h8);

        // Stall for 3 cycles while the 0x8 word is acked
        chk("stall_addr", imem_bus.imem_addr, 32'h8);
        tick();
        stall               = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(32'h8);
        tick();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("hold_req_a", 32'(imem_bus.imem_req), 32'h0);
        chk_ifid("hold_a", 1'b1, w(32'h4), 32'h8);
        tick();
        chk("hold_req_b", 32'(imem_bus.imem_req), 32'h0);
        chk_ifid("hold_b", 1'b1, w(32'h4), 32'h8);
        tick();
        chk_ifid("hold_c", 1'b1, w(32'h4), 32'h8);
        stall = 1'b0;
        tick();
        chk_ifid("unskid", 1'b1, w(32'h8), 32'hC);
        zw(32'hC);
        chk_ifid("seqC", 1'b1, w(32'hC), 32'h10);

        // Branch while request to 0x10 is outstanding, ack two cycles later
        chk("drain_addr0", imem_bus.imem_addr, 32'h10);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        chk("drain_req", 32'(imem_bus.imem_req), 32'h1);
        chk("drain_addr1", imem_bus.imem_addr, 32'h10);
        chk("drain_valid", 32'(if_valid), 32'h0);
        chk("drain_instr", if_instr, 32'h0);
        tick();
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(32'h10);
        tick();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("drain_discard_valid", 32'(if_valid), 32'h0);
        chk("drain_discard_instr", if_instr, 32'h0);
        zw(32'h40);
        chk_ifid("seq40", 1'b1, w(32'h40), 32'h44);

        // Branch and jump together: branch wins
        chk("both_addr0", imem_bus.imem_addr, 32'h44);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        jump          = 1'b1;
        jump_index    = 26'h3;
        tick();
        branch_taken  = 1'b0;
        jump          = 1'b0;
        chk("both_valid", 32'(if_valid), 32'h0);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(32'h44);
        tick();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("both_addr1", imem_bus.imem_addr, 32'h100);
        chk("both_valid2", 32'(if_valid), 32'h0);

        // Branch acked in the redirect cycle: move to 0x10 to set up the jump test
        branch_taken        = 1'b1;
        branch_target       = 32'h10;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(32'h100);
        tick();
        branch_taken        = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("backed_valid", 32'(if_valid), 32'h0);
        zw(32'h10);
        chk_ifid("seq10", 1'b1, w(32'h10), 32'h14);

        // Jump from ID with if_pc4=0x14, acked in the same cycle
        jump                = 1'b1;
        jump_index          = 26'h0000010;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(32'h14);
        tick();
        jump                = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("jump_valid", 32'(if_valid), 32'h0);
        chk("jump_instr", if_instr, 32'h0);
        chk("jump_opcode", 32'(opcode), 32'h0);
        chk("jump_addr", imem_bus.imem_addr, 32'h40);

        // PC wrap at the top of the address space
        branch_taken        = 1'b1;
        branch_target       = 32'hFFFF_FFFC;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(32'h40);
        tick();
        branch_taken        = 1'b0;
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        zw(32'hFFFF_FFFC);
        chk_ifid("wrap", 1'b1, w(32'hFFFF_FFFC), 32'h0);
        chk("wrap_addr", imem_bus.imem_addr, 32'h0);

        // Async reset mid-request, then a stale ack across deassertion
        chk("pre_rst_req", 32'(imem_bus.imem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_req", 32'(imem_bus.imem_req), 32'h0);
        chk("async_valid", 32'(if_valid), 32'h0);
        chk("async_instr", if_instr, 32'h0);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = w(32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("post_rst_valid", 32'(if_valid), 32'h0);
        zw(32'h0);
        chk_ifid("post_rst_seq0", 1'b1, w(32'h0), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder/control unit.
- Holds the PC and fetches words from instruction memory over a req/ack handshake.
- Registers the fetched word into an IF/ID register and presents opcode = instr[31:26] to control.
- Takes redirects from downstream: resolved beq/bne from EX, j from ID. Handles stalls and flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_WIDTH, 32, width of PC and memory address.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  PC_WIDTH  fetch address, stable while imem_req=1.
- imem_ack  in  1  memory response valid; imem_rdata sampled this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  hazard stall from ID; IF/ID register must hold.
- branch_taken  in  1  EX-resolved taken beq/bne, i.e. (Beq&zero)|(Bne&~zero).
- branch_target  in  PC_WIDTH  branch destination.
- jump  in  1  Jump decoded in ID.
- jump_index  in  26  instr[25:0] of the jump in ID.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_instr  out  32  IF/ID instruction; 32'h0 when invalid.
- if_pc4  out  PC_WIDTH  PC+4 of the if_instr instruction.
- opcode  out  6  if_instr[31:26] to control; 6'b000000 when invalid.

Behaviour:
- Reset (async):
  - pc=RESET_PC; state=FETCH; imem_req=0 during reset, 1 from the first clock edge after rst deasserts.
  - if_valid=0, if_instr=0, if_pc4=0, skid buffer empty, kill flag=0.
- States: FETCH, HOLD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=req_addr. req_addr is latched when a request starts and only changes when a new request starts.
  - On ack with stall=0: IF/ID <= {rdata, req_addr+4}, if_valid=1, pc<=pc+4, new request next cycle. Throughput is one instruction per ack; minimum latency is one cycle from ack to if_valid.
  - On ack with stall=1: rdata and req_addr+4 go to the skid buffer; pc<=pc+4; next state HOLD.
- HOLD:
  - imem_req=0.
  - When stall falls: IF/ID <= skid buffer, if_valid=1, go to FETCH.
- Stall without ack: IF/ID register unchanged; the request stays outstanding.
- Redirect (branch_taken | jump), evaluated every cycle, highest priority over stall and ack:
  - branch_taken beats jump when both are asserted (EX is older than ID).
  - New pc = branch_target, or {if_pc4[31:28], jump_index, 2'b00} for a jump.
  - Next cycle: if_valid=0, if_instr=0 (flush), skid buffer cleared.
  - If a request is outstanding and not acked in the redirect cycle: go to DRAIN. Keep imem_req=1 at the old address, discard the data on ack, then FETCH at the new pc.
  - If acked in the redirect cycle: discard the data, FETCH at the new pc next cycle.
  - In HOLD: discard the buffer, go to FETCH.
- DRAIN:
  - Further redirects overwrite pc only.
  - stall is ignored.
- PC arithmetic:
  - Modulo 2^PC_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
  - Low two bits are not checked; the address is issued as given.
- Async reset mid-request: imem_req drops immediately and any in-flight ack is ignored until the first post-reset request.
- No combinational path from imem_rdata to the outputs. imem_req/imem_addr depend only on registers.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - fetch_count increments on every ack that is not discarded.
  - stall_count increments on every cycle where stall=1 and if_valid=1.
- When undefined: neither the ports nor the registers exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0 and a zero-wait memory (ack the cycle after req) -> addresses 0,4,8 issued on consecutive requests; if_pc4 = 4,8,12; opcode tracks instr[31:26].
- Stall=1 for 3 cycles while the word at 0x8 is acked -> if_instr holds the word from 0x4, the 0x8 word waits in the skid buffer with imem_req=0, and it appears one cycle after stall falls.
- branch_taken=1, branch_target=0x40, while a request to 0x10 is outstanding (ack 2 cycles later) -> DRAIN; the 0x10 data is discarded, if_valid=0, next imem_addr=0x40.
- jump=1, jump_index=26'h0000010, if_pc4=0x0000_0014 -> next fetch address 0x0000_0040; the IF/ID register is flushed.
- branch_taken and jump asserted in the same cycle, branch_target=0x100 -> fetch from 0x100; the jump is ignored.
- pc=0xFFFF_FFFC acked -> next address 0x0000_0000. Assert rst while imem_req=1 -> imem_req=0 and if_valid=0 immediately, without waiting for a clock edge.
